// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe
//   Two-stage pipelined integer ALU. S1 latches the issued op, operands and
//   tags; S2 computes the result from S1 and registers it together with the
//   tags. out_* are driven straight from the S2 register, so nothing on in_*
//   reaches out_* combinationally. Valid/ready on both sides; one op per
//   cycle while the writeback side is ready; flush squashes everything in
//   flight.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           squash all in-flight ops (no op accepted that cycle)
//   in_valid/ready  issue handshake
//   in_alu_control  op: 0 ADD,1 SUB,2 XOR,3 OR,4 AND,5 SLL,6 SRL,7 SRA,
//                   8 SLT,9 SLTU; any other encoding executes as ADD
//   in_op_a/b       operands
//   in_prd/rob_idx  destination tag / ROB entry, passed through
//   out_valid/ready writeback handshake
//   out_result      ALU result
//   out_prd/rob_idx tag passthrough
module alu_exec_pipe #(
    parameter int XLEN   = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_control,
    input  logic [XLEN-1:0]   in_op_a,
    input  logic [XLEN-1:0]   in_op_b,
    input  logic [PREG_W-1:0] in_prd,
    input  logic [ROB_W-1:0]  in_rob_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [PREG_W-1:0] out_prd,
    output logic [ROB_W-1:0]  out_rob_idx
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    // S1: operand latch
    logic              r_s1_valid;
    logic [3:0]        r_s1_op;
    logic [XLEN-1:0]   r_s1_a;
    logic [XLEN-1:0]   r_s1_b;
    logic [PREG_W-1:0] r_s1_prd;
    logic [ROB_W-1:0]  r_s1_rob;

    // S2: result register, drives out_*
    logic              r_s2_valid;
    logic [XLEN-1:0]   r_s2_result;
    logic [PREG_W-1:0] r_s2_prd;
    logic [ROB_W-1:0]  r_s2_rob;

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic [SHW-1:0]         w_shamt;
    logic signed [XLEN-1:0] w_sra;
    logic                   w_slt;
    logic                   w_sltu;
    logic [XLEN-1:0]        w_result;

    // A stage may take new contents when it is empty or its occupant moves on.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_shamt = r_s1_b[SHW-1:0];
    assign w_sra   = $signed(r_s1_a) >>> w_shamt;
    assign w_slt   = $signed(r_s1_a) < $signed(r_s1_b);
    assign w_sltu  = r_s1_a < r_s1_b;

    always_comb begin
        w_result = r_s1_a + r_s1_b;
        case (r_s1_op)
            OP_ADD:  w_result = r_s1_a + r_s1_b;
            OP_SUB:  w_result = r_s1_a - r_s1_b;
            OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_SLL:  w_result = r_s1_a << w_shamt;
            OP_SRL:  w_result = r_s1_a >> w_shamt;
            OP_SRA:  w_result = w_sra;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_slt};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_sltu};
            default: w_result = r_s1_a + r_s1_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_prd    <= '0;
            r_s1_rob    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_prd    <= '0;
            r_s2_rob    <= '0;
        end else if (flush) begin
            // Data registers keep stale contents; only the valids matter.
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_result <= w_result;
                    r_s2_prd    <= r_s1_prd;
                    r_s2_rob    <= r_s1_rob;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_op  <= in_alu_control;
                    r_s1_a   <= in_op_a;
                    r_s1_b   <= in_op_b;
                    r_s1_prd <= in_prd;
                    r_s1_rob <= in_rob_idx;
                end
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_s2_result;
    assign out_prd     = r_s2_prd;
    assign out_rob_idx = r_s2_rob;

endmodule
